// File: rtl/nfca_sched_pkg.sv
// Shared types for the NFC-A frame scheduler: FSM state encoding and the
// packed transmit-word layout {tdata[7:0], tdatab[3:0], tlast}.
package nfca_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_RX,
    GUARD,
    REPLAY
  } state_t;

  // Width of one packed transmit word {tdata, tdatab, tlast}
  localparam int TX_W = 13;

  // Pack one transmit beat into the buffer word layout
  function automatic logic [TX_W-1:0] pack_tx(input logic [7:0] data,
                                              input logic [3:0] datab,
                                              input logic       last);
    return {data, datab, last};
  endfunction

endpackage

// File: rtl/nfca_frame_buf.sv
// Retry buffer for the frame scheduler: simple dual-port RAM holding the
// bytes of the current frame, a write pointer that doubles as the frame
// length, an overflow flag for frames longer than the RAM, and a registered
// (1-cycle) read port. Only instantiated when NFCA_SCHED_RETRY_EN is defined.
module nfca_frame_buf
  import nfca_sched_pkg::*;
#(
  parameter int ASIZE = 6
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            clr,
  input  logic            wr_en,
  input  logic [TX_W-1:0] wr_data,
  input  logic [ASIZE-1:0] rd_addr,
  output logic [TX_W-1:0] rd_data,
  output logic            overflow
);

  localparam int DEPTH_I = 2 ** ASIZE;
  localparam logic [ASIZE:0] DEPTH = (ASIZE + 1)'(DEPTH_I);

  logic [TX_W-1:0] mem [0:DEPTH_I-1];
  logic [ASIZE:0]  len_reg;
  logic            ovf_reg;

  // RAM write: bytes beyond the RAM depth are discarded
  always_ff @(posedge clk) begin
    if (wr_en && !clr && (len_reg < DEPTH)) begin
      mem[len_reg[ASIZE-1:0]] <= wr_data;
    end
  end

  // Registered read port, no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    rd_data <= mem[rd_addr];
  end

  // Length / overflow tracking, restarted at the first byte of each frame
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      len_reg <= '0;
      ovf_reg <= 1'b0;
    end else if (clr) begin
      len_reg <= '0;
      ovf_reg <= 1'b0;
    end else if (wr_en) begin
      if (len_reg == DEPTH) begin
        ovf_reg <= 1'b1;
      end else begin
        len_reg <= len_reg + (ASIZE + 1)'(1);
      end
    end
  end

  assign overflow = ovf_reg;

endmodule

// File: rtl/nfca_frame_scheduler.sv
// Sequences ISO14443A command frames from the command FIFO into the NFC-A
// controller one at a time: pass-through while sending, then wait for the
// card response (rx_tend) or a timeout, then hold a guard gap before the
// next frame. Optional macro NFCA_SCHED_RETRY_EN adds a one-shot replay of
// a frame whose first exchange timed out.
module nfca_frame_scheduler
  import nfca_sched_pkg::*;
#(
  parameter int GUARD_CYCLES = 8136,
  parameter int RX_TIMEOUT   = 813600,
  parameter int CNT_W        = 24,
  parameter int BUF_ASIZE    = 6
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       s_tvalid,
  output logic       s_tready,
  input  logic [7:0] s_tdata,
  input  logic [3:0] s_tdatab,
  input  logic       s_tlast,
  output logic       m_tvalid,
  input  logic       m_tready,
  output logic [7:0] m_tdata,
  output logic [3:0] m_tdatab,
  output logic       m_tlast,
  input  logic       rx_tend,
  input  logic       rx_terr,
  output logic       timeout,
  output logic       busy
);

  localparam logic [CNT_W-1:0] RX_LAST    = CNT_W'(RX_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             timeout_reg;
  logic             s_hs;
  logic             guard_done;

  // Shared counter saturates instead of wrapping
  assign cnt_next   = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_W'(1);
  assign s_hs       = (state_reg == SEND) && s_tvalid && m_tready;
  assign guard_done = (cnt_reg == GUARD_LAST);

`ifdef NFCA_SCHED_RETRY_EN
  logic [TX_W-1:0]      buf_rd_data;
  logic                 buf_ovf;
  logic                 rep_valid_reg;
  logic                 retried_reg;
  logic                 replay_pend_reg;
  logic                 frame_start;
  logic                 rep_hs;
  logic [BUF_ASIZE-1:0] rd_ptr_reg;
  logic [BUF_ASIZE-1:0] rd_addr;
  logic                 unused_terr;

  assign unused_terr = rx_terr;
  assign rep_hs      = (state_reg == REPLAY) && rep_valid_reg && m_tready;
  // Look one word ahead on a handshake so replayed bytes stream back to back
  assign rd_addr     = rep_hs ? rd_ptr_reg + BUF_ASIZE'(1) : rd_ptr_reg;
  assign frame_start = s_tvalid &&
                       ((state_reg == IDLE) ||
                        ((state_reg == GUARD) && guard_done && !replay_pend_reg));

  nfca_frame_buf #(
    .ASIZE(BUF_ASIZE)
  ) u_buf (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (frame_start),
    .wr_en   (s_hs),
    .wr_data (pack_tx(s_tdata, s_tdatab, s_tlast)),
    .rd_addr (rd_addr),
    .rd_data (buf_rd_data),
    .overflow(buf_ovf)
  );
`else
  logic unused_cfg;

  // rx_terr is informational; retry depth only matters with the buffer built in
  assign unused_cfg = rx_terr ^ BUF_ASIZE[0];
`endif

  // Output steering: zero-latency pass-through in SEND, buffer data in REPLAY
  always_comb begin
    s_tready = 1'b0;
    m_tvalid = 1'b0;
    m_tdata  = 8'h00;
    m_tdatab = 4'h0;
    m_tlast  = 1'b0;
    if (state_reg == SEND) begin
      s_tready = m_tready;
      m_tvalid = s_tvalid;
      m_tdata  = s_tdata;
      m_tdatab = s_tdatab;
      m_tlast  = s_tlast;
    end
`ifdef NFCA_SCHED_RETRY_EN
    else if ((state_reg == REPLAY) && rep_valid_reg) begin
      m_tvalid = 1'b1;
      {m_tdata, m_tdatab, m_tlast} = buf_rd_data;
    end
`endif
  end

  // Frame sequencing FSM with the shared guard/timeout counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      timeout_reg     <= 1'b0;
`ifdef NFCA_SCHED_RETRY_EN
      replay_pend_reg <= 1'b0;
      retried_reg     <= 1'b0;
      rep_valid_reg   <= 1'b0;
      rd_ptr_reg      <= '0;
`endif
    end else begin
      timeout_reg <= 1'b0;
`ifdef NFCA_SCHED_RETRY_EN
      if (frame_start) begin
        retried_reg <= 1'b0;
      end
`endif
      case (state_reg)
        IDLE: begin
          if (s_tvalid) begin
            state_reg <= SEND;
          end
        end
        SEND: begin
          if (s_hs && s_tlast) begin
            state_reg <= WAIT_RX;
            cnt_reg   <= '0;
          end
        end
        WAIT_RX: begin
          if (rx_tend) begin
            // A response ends the wait even if expiry falls in the same cycle
            state_reg <= GUARD;
            cnt_reg   <= '0;
          end else if (timeout_reg) begin
            state_reg <= GUARD;
            cnt_reg   <= '0;
`ifdef NFCA_SCHED_RETRY_EN
            if (!retried_reg && !buf_ovf) begin
              replay_pend_reg <= 1'b1;
            end
`endif
          end else begin
            if (cnt_reg == RX_LAST) begin
              timeout_reg <= 1'b1;
            end
            cnt_reg <= cnt_next;
          end
        end
        GUARD: begin
          if (guard_done) begin
            cnt_reg <= '0;
`ifdef NFCA_SCHED_RETRY_EN
            if (replay_pend_reg) begin
              state_reg       <= REPLAY;
              replay_pend_reg <= 1'b0;
              retried_reg     <= 1'b1;
              rd_ptr_reg      <= '0;
              rep_valid_reg   <= 1'b0;
            end else
`endif
            if (s_tvalid) begin
              state_reg <= SEND;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            cnt_reg <= cnt_next;
          end
        end
`ifdef NFCA_SCHED_RETRY_EN
        REPLAY: begin
          rep_valid_reg <= 1'b1;
          rd_ptr_reg    <= rd_addr;
          if (rep_hs && buf_rd_data[0]) begin
            state_reg     <= WAIT_RX;
            cnt_reg       <= '0;
            rep_valid_reg <= 1'b0;
          end
        end
`endif
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign timeout = timeout_reg;
  assign busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_nfca_frame_scheduler.sv
// Directed bench for nfca_frame_scheduler with short guard/timeout values.
`timescale 1ns/1ps
module tb_nfca_frame_scheduler;

  localparam int GUARD_CYCLES = 20;
  localparam int RX_TIMEOUT   = 100;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       s_tvalid = 1'b0;
  logic       s_tready;
  logic [7:0] s_tdata = 8'h00;
  logic [3:0] s_tdatab = 4'h0;
  logic       s_tlast = 1'b0;
  logic       m_tvalid;
  logic       m_tready = 1'b1;
  logic [7:0] m_tdata;
  logic [3:0] m_tdatab;
  logic       m_tlast;
  logic       rx_tend = 1'b0;
  logic       rx_terr = 1'b0;
  logic       timeout;
  logic       busy;

  int n_cmp = 0;
  int n_mis = 0;
  int to_count = 0;

  nfca_frame_scheduler #(
    .GUARD_CYCLES(GUARD_CYCLES),
    .RX_TIMEOUT  (RX_TIMEOUT),
    .CNT_W       (24),
    .BUF_ASIZE   (6)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .s_tvalid(s_tvalid),
    .s_tready(s_tready),
    .s_tdata (s_tdata),
    .s_tdatab(s_tdatab),
    .s_tlast (s_tlast),
    .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .m_tdata (m_tdata),
    .m_tdatab(m_tdatab),
    .m_tlast (m_tlast),
    .rx_tend (rx_tend),
    .rx_terr (rx_terr),
    .timeout (timeout),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Count timeout pulses, sampled mid-cycle
  always @(negedge clk) begin
    if (timeout) to_count++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte and wait for its handshake; returns one step after the accepting edge
  task automatic send_byte(input string tag, input logic [7:0] d, input logic [3:0] b, input logic l);
    bit done;
    done = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tdatab = b;
    s_tlast  = l;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (s_tready) begin
        check({tag, "_mvalid"}, m_tvalid, 1'b1);
        check({tag, "_mdata"}, m_tdata, d);
        check({tag, "_mdatab"}, m_tdatab, b);
        check({tag, "_mlast"}, m_tlast, l);
        done = 1;
      end
      tick();
    end
    if (!done) check({tag, "_accept"}, s_tready, 1'b1);
    s_tvalid = 1'b0;
  endtask

  // Count cycles (first = 1) until: 0 timeout high, 1 busy low, 2 m_tvalid high
  task automatic wait_for(input int which, output int j);
    logic hit;
    hit = 1'b0;
    j = 0;
    while (!hit && j < 400) begin
      if (j > 0) tick();
      j++;
      @(negedge clk);
      case (which)
        0:       hit = timeout;
        1:       hit = !busy;
        default: hit = m_tvalid;
      endcase
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_stready"}, s_tready, 1'b0);
    check({tag, "_mvalid"}, m_tvalid, 1'b0);
    check({tag, "_mlast"}, m_tlast, 1'b0);
    check({tag, "_mdata"}, m_tdata, 8'h00);
    check({tag, "_mdatab"}, m_tdatab, 4'h0);
    check({tag, "_timeout"}, timeout, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    int j;
    int nvalid;
    logic [7:0] rep_exp [3];

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("rst");
    tick();
    rstn = 1'b1;
    tick();

    // 1: single short frame, response after 40 cycles, next frame after guard
    s_tvalid = 1'b1; s_tdata = 8'h26; s_tdatab = 4'd7; s_tlast = 1'b1;
    @(negedge clk);
    check("t1_idle_stready", s_tready, 1'b0);
    check("t1_idle_busy", busy, 1'b0);
    tick();
    send_byte("t1_b0", 8'h26, 4'd7, 1'b1);
    repeat (39) tick();
    rx_tend = 1'b1;
    m_tready = 1'b0;
    s_tvalid = 1'b1; s_tdata = 8'h93; s_tdatab = 4'd8; s_tlast = 1'b0;
    tick();
    rx_tend = 1'b0;
    wait_for(2, j);
    check("t1_gap_tend_to_mvalid", j, GUARD_CYCLES + 1);
    check("t1_stready_held", s_tready, 1'b0);
    check("t1_no_timeout", to_count, 0);
    tick();

    // 2: two-byte frame, no response -> timeout then guard
    m_tready = 1'b1;
    send_byte("t2_b0", 8'h93, 4'd8, 1'b0);
    send_byte("t2_b1", 8'h20, 4'd8, 1'b1);
    wait_for(0, j);
    check("t2_timeout_delay", j, RX_TIMEOUT + 1);
    tick();
    check("t2_timeout_pulse_width", timeout, 1'b0);
    wait_for(1, j);
    check("t2_busy_low_delay", j, GUARD_CYCLES + 1);
    check("t2_timeout_count", to_count, 1);
    tick();

    // 3: response on the expiry cycle wins, no timeout
    send_byte("t3_b0", 8'h30, 4'd8, 1'b1);
    repeat (RX_TIMEOUT - 1) tick();
    rx_tend = 1'b1;
    tick();
    rx_tend = 1'b0;
    wait_for(1, j);
    check("t3_guard_len", j, GUARD_CYCLES + 1);
    check("t3_timeout_count", to_count, 1);
    tick();

    // 4: stray rx_tend in IDLE is ignored, then zero-latency forward
    rx_tend = 1'b1;
    tick();
    rx_tend = 1'b0;
    @(negedge clk);
    check("t4_stray_tend_busy", busy, 1'b0);
    tick();
    m_tready = 1'b0;
    s_tvalid = 1'b1; s_tdata = 8'h52; s_tdatab = 4'd8; s_tlast = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_stall_stready", s_tready, 1'b0);
      check("t4_stall_mvalid", m_tvalid, 1'b1);
      check("t4_stall_mdata", m_tdata, 8'h52);
      tick();
    end
    m_tready = 1'b1;
    send_byte("t4_b0", 8'h52, 4'd8, 1'b1);
    repeat (5) tick();
    rx_tend = 1'b1; rx_terr = 1'b1;
    tick();
    rx_tend = 1'b0; rx_terr = 1'b0;
    wait_for(1, j);
    check("t4_errored_resp_guard", j, GUARD_CYCLES + 1);
    tick();

    // 5: reset during the second byte of a three-byte frame
    send_byte("t5_b0", 8'hA1, 4'd8, 1'b0);
    m_tready = 1'b0;
    s_tvalid = 1'b1; s_tdata = 8'hA2; s_tdatab = 4'd8; s_tlast = 1'b0;
    @(negedge clk);
    check("t5_inflight_mdata", m_tdata, 8'hA2);
    #2;
    rstn = 1'b0;
    #1;
    check_idle_outputs("t5_rst");
    @(negedge clk);
    rstn = 1'b1;
    tick();
    m_tready = 1'b1;
    send_byte("t5_new_b0", 8'hA2, 4'd8, 1'b0);
    send_byte("t5_new_b1", 8'hA3, 4'd8, 1'b1);
    check("t5_no_timeout", to_count, 1);
    repeat (3) tick();
    rx_tend = 1'b1;
    tick();
    rx_tend = 1'b0;
    wait_for(1, j);
    check("t5_idle_after", j, GUARD_CYCLES + 1);
    tick();

`ifdef NFCA_SCHED_RETRY_EN
    // 6: timeout, single replay of the frame, second timeout, no further send
    rep_exp[0] = 8'h11; rep_exp[1] = 8'h22; rep_exp[2] = 8'h33;
    send_byte("t6_b0", 8'h11, 4'd8, 1'b0);
    send_byte("t6_b1", 8'h22, 4'd8, 1'b0);
    send_byte("t6_b2", 8'h33, 4'd8, 1'b1);
    wait_for(0, j);
    check("t6_timeout1_delay", j, RX_TIMEOUT + 1);
    tick();
    wait_for(2, j);
    check("t6_replay_start", j, GUARD_CYCLES + 2);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        tick();
        @(negedge clk);
      end
      check("t6_rep_mvalid", m_tvalid, 1'b1);
      check("t6_rep_mdata", m_tdata, rep_exp[i]);
      check("t6_rep_mlast", m_tlast, (i == 2) ? 1'b1 : 1'b0);
      check("t6_rep_stready", s_tready, 1'b0);
    end
    tick();
    wait_for(0, j);
    check("t6_timeout2_delay", j, RX_TIMEOUT + 1);
    tick();
    wait_for(1, j);
    check("t6_busy_low", j, GUARD_CYCLES + 1);
    nvalid = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (m_tvalid) nvalid++;
    end
    check("t6_no_third_send", nvalid, 0);
    check("t6_timeout_count", to_count, 3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
